// File: rtl/prog_fsm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// prog_fsm_ctrl_pkg
//
// Shared types and constants for the programmable Moore FSM controller:
//   - state_t and the A/B/C/D state encodings, RESET_STATE
//   - mode_t (controller mode: IDLE / RUN)
//   - cfg_type encodings (next-state entry vs output entry)
//   - reset contents of the 16x2 next-state table and the 4x1 output table
//   - ns_idx(): forms the next-state table index {state, in_}
// -----------------------------------------------------------------------------
package prog_fsm_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_A = 2'd0;
    localparam state_t ST_B = 2'd1;
    localparam state_t ST_C = 2'd2;
    localparam state_t ST_D = 2'd3;

    localparam state_t RESET_STATE = ST_A;

    typedef enum logic {
        MODE_IDLE = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    localparam logic CFG_TYPE_NS  = 1'b0;
    localparam logic CFG_TYPE_OUT = 1'b1;

    localparam logic [15:0] STEP_COUNT_MAX = 16'hFFFF;

    // Next-state table, index {state[1:0], in_[1:0]}, listed from entry 15
    // down to entry 0 (one row per state, in_=11 first within each row).
    //   A: 00->A 01->B 10->A 11->D
    //   B: 00->C 01->B 10->A 11->D
    //   C: 00->A 01->D 10->A 11->D
    //   D: 00->C 01->B 10->A 11->D
    localparam logic [15:0][1:0] NS_TBL_RST = {
        ST_D, ST_A, ST_B, ST_C,   // D row, entries 15..12
        ST_D, ST_A, ST_D, ST_A,   // C row, entries 11..8
        ST_D, ST_A, ST_B, ST_C,   // B row, entries 7..4
        ST_D, ST_A, ST_B, ST_A    // A row, entries 3..0
    };

    // Output table, bit index = state: only D drives 1.
    localparam logic [3:0] OUT_TBL_RST = 4'b1000;

    function automatic logic [3:0] ns_idx(input state_t st, input logic [1:0] in_tok);
        return {st, in_tok};
    endfunction

endpackage

// File: rtl/prog_fsm_ctrl_table.sv
// -----------------------------------------------------------------------------
// prog_fsm_ctrl_table
//
// Register file holding the programmable FSM tables:
//   - 16x2 next-state table, indexed by {state, in_}
//   - 4x1 output table, indexed by state
// One write port (type selects which table), one combinational read port per
// table. Asynchronous active-low reset loads the package reset contents.
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   wr_en        in   write strobe (one entry updated at the clock edge)
//   wr_type      in   CFG_TYPE_NS / CFG_TYPE_OUT
//   wr_addr[3:0] in   NS: {state, in_}; OUT: [1:0] = state, [3:2] ignored
//   wr_data[1:0] in   NS: next state; OUT: bit 0 = output, bit 1 ignored
//   ns_rd_idx    in   next-state read index
//   ns_rd_data   out  next-state read data
//   out_rd_state in   output-table read index
//   out_rd_data  out  output-table read data
// -----------------------------------------------------------------------------
module prog_fsm_ctrl_table
    import prog_fsm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic       wr_type,
    input  logic [3:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic [3:0] ns_rd_idx,
    output state_t     ns_rd_data,
    input  state_t     out_rd_state,
    output logic       out_rd_data
);

    logic [15:0][1:0] ns_tbl_q;
    logic [15:0][1:0] ns_tbl_d;
    logic [3:0]       out_tbl_q;
    logic [3:0]       out_tbl_d;

    always_comb begin
        ns_tbl_d  = ns_tbl_q;
        out_tbl_d = out_tbl_q;
        if (wr_en) begin
            if (wr_type == CFG_TYPE_NS) begin
                ns_tbl_d[wr_addr] = wr_data;
            end else begin
                out_tbl_d[wr_addr[1:0]] = wr_data[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ns_tbl_q  <= NS_TBL_RST;
            out_tbl_q <= OUT_TBL_RST;
        end else begin
            ns_tbl_q  <= ns_tbl_d;
            out_tbl_q <= out_tbl_d;
        end
    end

    assign ns_rd_data  = ns_tbl_q[ns_rd_idx];
    assign out_rd_data = out_tbl_q[out_rd_state];

endmodule

// File: rtl/prog_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// prog_fsm_ctrl
//
// Controller for a programmable 4-state, 2-input, 1-output Moore FSM.
// Tables are written through the config port while IDLE; in RUN the FSM takes
// one transition per accepted input token.
//
//   mode      | meaning
//   ----------+-----------------------------------------------------------
//   MODE_IDLE | config writes accepted, state held at RESET_STATE, go -> RUN
//   MODE_RUN  | tokens step the FSM, config stalled, halt -> IDLE
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   go, halt          mode control pulses
//   busy              1 in RUN
//   cfg_val/cfg_rdy   config write handshake (cfg_rdy only in IDLE)
//   cfg_type/addr/data config write payload
//   in_val/in_rdy/in_ input token handshake and value
//   state             current FSM state (registered)
//   out               Moore output, out_tbl[state]
//   out_val           1-cycle pulse the cycle after each accepted token
//   step_count        accepted-token counter, saturating; only present when
//                     PROG_FSM_CTRL_STEP_COUNT_EN is defined
// -----------------------------------------------------------------------------
module prog_fsm_ctrl
    import prog_fsm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic        halt,
    output logic        busy,
    input  logic        cfg_val,
    output logic        cfg_rdy,
    input  logic        cfg_type,
    input  logic [3:0]  cfg_addr,
    input  logic [1:0]  cfg_data,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [1:0]  in_,
    output logic [1:0]  state,
    output logic        out,
    output logic        out_val
`ifdef PROG_FSM_CTRL_STEP_COUNT_EN
    ,
    output logic [15:0] step_count
`endif
);

    mode_t  mode_q;
    mode_t  mode_d;
    state_t state_q;
    state_t state_d;
    logic   out_val_q;
    logic   out_val_d;

    state_t ns_next;
    logic   out_cur;
    logic   cfg_fire;
    logic   tok_acc;

    assign busy     = (mode_q == MODE_RUN);
    assign cfg_rdy  = (mode_q == MODE_IDLE);
    assign in_rdy   = busy && !halt;
    assign cfg_fire = cfg_val && cfg_rdy;
    assign tok_acc  = in_val && in_rdy;

    prog_fsm_ctrl_table u_table (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (cfg_fire),
        .wr_type      (cfg_type),
        .wr_addr      (cfg_addr),
        .wr_data      (cfg_data),
        .ns_rd_idx    (ns_idx(state_q, in_)),
        .ns_rd_data   (ns_next),
        .out_rd_state (state_q),
        .out_rd_data  (out_cur)
    );

    always_comb begin
        mode_d    = mode_q;
        state_d   = state_q;
        out_val_d = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                state_d = RESET_STATE;
                if (go) begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_RUN: begin
                // halt masks in_rdy, so a token in the halt cycle is dropped
                if (halt) begin
                    mode_d  = MODE_IDLE;
                    state_d = RESET_STATE;
                end else if (tok_acc) begin
                    state_d   = ns_next;
                    out_val_d = 1'b1;
                end
            end
            default: begin
                mode_d  = MODE_IDLE;
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_IDLE;
            state_q   <= RESET_STATE;
            out_val_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            state_q   <= state_d;
            out_val_q <= out_val_d;
        end
    end

    assign state   = state_q;
    assign out     = out_cur;
    assign out_val = out_val_q;

`ifdef PROG_FSM_CTRL_STEP_COUNT_EN
    logic [15:0] step_count_q;
    logic [15:0] step_count_d;

    always_comb begin
        step_count_d = step_count_q;
        if ((mode_q == MODE_IDLE) && go) begin
            step_count_d = '0;
        end else if (tok_acc && (step_count_q != STEP_COUNT_MAX)) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_count_q <= '0;
        end else begin
            step_count_q <= step_count_d;
        end
    end

    assign step_count = step_count_q;
`endif

endmodule

// File: tb/tb_prog_fsm_ctrl.sv
module tb_prog_fsm_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic        halt = 1'b0;
    logic        busy;
    logic        cfg_val = 1'b0;
    logic        cfg_rdy;
    logic        cfg_type = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [1:0]  cfg_data = 2'd0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [1:0]  in_ = 2'd0;
    logic [1:0]  state;
    logic        out;
    logic        out_val;
`ifdef PROG_FSM_CTRL_STEP_COUNT_EN
    logic [15:0] step_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] st;
        logic       o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    prog_fsm_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .halt       (halt),
        .busy       (busy),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .cfg_type   (cfg_type),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_        (in_),
        .state      (state),
        .out        (out),
        .out_val    (out_val)
`ifdef PROG_FSM_CTRL_STEP_COUNT_EN
        ,
        .step_count (step_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every out_val pulse is matched against the next expected step.
    always @(negedge clk) begin
        if (reset_n && out_val) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL extra_out_val: out_val=1 state=%0d out=%0d, expected no pulse", state, out);
            end else begin
                mon_e = exp_q.pop_front();
                if (state !== mon_e.st || out !== mon_e.o) begin
                    failures++;
                    $display("FAIL step: state=%0d out=%0d, expected state=%0d out=%0d",
                             state, out, mon_e.st, mon_e.o);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    task automatic send_tok(input logic [1:0] tok, input logic [1:0] exp_st, input logic exp_o);
        exp_t e;
        e.st = exp_st;
        e.o  = exp_o;
        exp_q.push_back(e);
        in_val = 1'b1;
        in_    = tok;
        tick();
        in_val = 1'b0;
    endtask

    task automatic cfg_write(input logic typ, input logic [3:0] addr, input logic [1:0] data);
        cfg_val  = 1'b1;
        cfg_type = typ;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_val  = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_cfg_rdy", 16'(cfg_rdy), 16'd1);
        chk("rst_in_rdy", 16'(in_rdy), 16'd0);
        chk("rst_out_val", 16'(out_val), 16'd0);
        chk("rst_out", 16'(out), 16'd0);
        #3 reset_n = 1'b1;
        tick();

        // default tables, back-to-back tokens
        pulse_go();
        chk("run_busy", 16'(busy), 16'd1);
        chk("run_cfg_rdy", 16'(cfg_rdy), 16'd0);
        chk("run_in_rdy", 16'(in_rdy), 16'd1);
        send_tok(2'b01, 2'd1, 1'b0);
        send_tok(2'b00, 2'd2, 1'b0);
        send_tok(2'b01, 2'd3, 1'b1);
        send_tok(2'b11, 2'd3, 1'b1);
        send_tok(2'b00, 2'd2, 1'b0);
        tick();
        chk("no_pulse_idle_run", 16'(out_val), 16'd0);
        pulse_halt();
        chk("halt_busy", 16'(busy), 16'd0);
        chk("halt_state", 16'(state), 16'd0);

        // program {A,00}->D and out[C]=1
        cfg_write(1'b0, 4'b0000, 2'd3);
        cfg_write(1'b1, 4'b0010, 2'd1);
        pulse_go();
        send_tok(2'b00, 2'd3, 1'b1);
        tick();
        pulse_halt();
        pulse_go();
        send_tok(2'b00, 2'd3, 1'b1);
        tick();
        pulse_halt();
        pulse_go();
        send_tok(2'b01, 2'd1, 1'b0);
        send_tok(2'b00, 2'd2, 1'b1);
        tick();
        pulse_halt();

        // go and cfg write in the same cycle: {A,01}->C used by first step
        cfg_val  = 1'b1;
        cfg_type = 1'b0;
        cfg_addr = 4'b0001;
        cfg_data = 2'd2;
        go       = 1'b1;
        tick();
        cfg_val  = 1'b0;
        go       = 1'b0;
        send_tok(2'b01, 2'd2, 1'b1);
        tick();
        pulse_halt();

        // config write stalls in RUN, lands after halt
        pulse_go();
        cfg_val  = 1'b1;
        cfg_type = 1'b0;
        cfg_addr = 4'b0010;
        cfg_data = 2'd1;
        #1;
        chk("stall_cfg_rdy", 16'(cfg_rdy), 16'd0);
        send_tok(2'b10, 2'd0, 1'b0);   // old entry {A,10}->A still in use
        tick();
        pulse_halt();
        chk("post_halt_cfg_rdy", 16'(cfg_rdy), 16'd1);
        chk("post_halt_state", 16'(state), 16'd0);
        tick();
        cfg_val = 1'b0;
        pulse_go();
        send_tok(2'b10, 2'd1, 1'b0);   // new entry {A,10}->B
        tick();
        pulse_halt();

        // halt and token in the same cycle: halt wins
        pulse_go();
        send_tok(2'b11, 2'd3, 1'b1);
        halt   = 1'b1;
        in_val = 1'b1;
        in_    = 2'b11;
        #1;
        chk("halt_in_rdy", 16'(in_rdy), 16'd0);
        tick();
        halt   = 1'b0;
        in_val = 1'b0;
        chk("halt_tok_out_val", 16'(out_val), 16'd0);
        chk("halt_tok_state", 16'(state), 16'd0);
        chk("halt_tok_busy", 16'(busy), 16'd0);

        // async reset mid-RUN with state D and modified tables
        pulse_go();
        in_val = 1'b1;
        in_    = 2'b11;
        tick();
        in_val = 1'b0;
        chk("pre_rst_state", 16'(state), 16'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 16'(state), 16'd0);
        chk("arst_out", 16'(out), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_out_val", 16'(out_val), 16'd0);
        chk("arst_cfg_rdy", 16'(cfg_rdy), 16'd1);
        #3 reset_n = 1'b1;
        tick();
        // tables back to reset contents
        pulse_go();
        send_tok(2'b00, 2'd0, 1'b0);
        send_tok(2'b01, 2'd1, 1'b0);
        send_tok(2'b00, 2'd2, 1'b0);
        send_tok(2'b10, 2'd0, 1'b0);
        tick();
        pulse_halt();

`ifdef PROG_FSM_CTRL_STEP_COUNT_EN
        pulse_go();
        chk("cnt_go_clear", step_count, 16'd0);
        send_tok(2'b01, 2'd1, 1'b0);
        send_tok(2'b00, 2'd2, 1'b0);
        send_tok(2'b01, 2'd3, 1'b1);
        send_tok(2'b11, 2'd3, 1'b1);
        send_tok(2'b00, 2'd2, 1'b0);
        tick();
        chk("cnt_five", step_count, 16'd5);
        pulse_halt();
        tick();
        tick();
        chk("cnt_hold_idle", step_count, 16'd5);
        pulse_go();
        chk("cnt_go_clear2", step_count, 16'd0);
        force dut.step_count_q = 16'hFFFD;
        #2;
        release dut.step_count_q;
        tick();
        send_tok(2'b00, 2'd0, 1'b0);
        send_tok(2'b00, 2'd0, 1'b0);
        send_tok(2'b00, 2'd0, 1'b0);
        tick();
        chk("cnt_saturate", step_count, 16'hFFFF);
        pulse_halt();
`endif

        tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
